// File: rtl/serial_magnitude_comparator.sv
// Bit-serial unsigned magnitude comparator: shifts two latched words out MSB-first
// and folds each bit pair into a registered greater/equal state.
module serial_magnitude_comparator #(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b0,
    localparam int IW        = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             greater_than,
    output logic             equal,
    output logic             less_than,
    output logic             x_bit,
    output logic             y_bit,
    output logic             bit_valid,
    output logic [IW-1:0]    bit_index
);

    // state | meaning
    // IDLE  | waiting for start; results hold the last compare
    // SHIFT | one bit pair per cycle folded into gt/eq
    // DONE  | one-cycle done pulse with results valid
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic             gt;
    logic             eq;
    logic [IW-1:0]    cnt;
    logic             in_shift;
    logic             diff;
    logic             gt_next;
    logic             eq_next;
    logic             last;

    assign in_shift = (state == SHIFT);

    always_comb begin
        busy      = (state != IDLE);
        done      = (state == DONE);
        bit_valid = in_shift;
        x_bit     = in_shift & sa[WIDTH-1];
        y_bit     = in_shift & sb[WIDTH-1];
        bit_index = in_shift ? cnt : '0;
    end

    // One stage of the comparator cascade, evaluated on the current bit pair.
    assign diff    = sa[WIDTH-1] ^ sb[WIDTH-1];
    assign gt_next = gt | (eq & sa[WIDTH-1] & ~sb[WIDTH-1]);
    assign eq_next = eq & ~diff;
    assign last    = (cnt == '0) || (EARLY_EXIT && eq && diff);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            sa           <= '0;
            sb           <= '0;
            gt           <= 1'b0;
            eq           <= 1'b0;
            cnt          <= '0;
            greater_than <= 1'b0;
            equal        <= 1'b0;
            less_than    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        gt    <= 1'b0;
                        eq    <= 1'b1;
                        cnt   <= IW'(WIDTH - 1);
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    gt  <= gt_next;
                    eq  <= eq_next;
                    sa  <= sa << 1;
                    sb  <= sb << 1;
                    cnt <= cnt - 1'b1;
                    if (last) begin
                        // Results are captured on entry so they line up with done.
                        greater_than <= gt_next;
                        equal        <= eq_next;
                        less_than    <= ~gt_next & ~eq_next;
                        state        <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Random and directed checks of serial_magnitude_comparator against a cycle-level
// transaction model, for WIDTH=8, WIDTH=8 with early exit, and WIDTH=1.
module tb_serial_magnitude_comparator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst;
    logic [2:0] start;
    logic [7:0] a_in [3];
    logic [7:0] b_in [3];
    logic [2:0] o_busy, o_done, o_gt, o_eq, o_lt, o_x, o_y, o_bv;
    logic [3:0] idx0, idx1;
    logic [0:0] idx2;

    int total = 0;
    int bad   = 0;
    bit run_chk = 1'b0;

    int wd [3] = '{8, 8, 1};
    bit ee [3] = '{1'b0, 1'b1, 1'b0};

    serial_magnitude_comparator #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut0 (
        .clk(clk), .reset(rst[0]), .start(start[0]), .a(a_in[0]), .b(b_in[0]),
        .busy(o_busy[0]), .done(o_done[0]), .greater_than(o_gt[0]), .equal(o_eq[0]),
        .less_than(o_lt[0]), .x_bit(o_x[0]), .y_bit(o_y[0]), .bit_valid(o_bv[0]),
        .bit_index(idx0));

    serial_magnitude_comparator #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut1 (
        .clk(clk), .reset(rst[1]), .start(start[1]), .a(a_in[1]), .b(b_in[1]),
        .busy(o_busy[1]), .done(o_done[1]), .greater_than(o_gt[1]), .equal(o_eq[1]),
        .less_than(o_lt[1]), .x_bit(o_x[1]), .y_bit(o_y[1]), .bit_valid(o_bv[1]),
        .bit_index(idx1));

    serial_magnitude_comparator #(.WIDTH(1), .EARLY_EXIT(1'b0)) dut2 (
        .clk(clk), .reset(rst[2]), .start(start[2]), .a(a_in[2][0:0]), .b(b_in[2][0:0]),
        .busy(o_busy[2]), .done(o_done[2]), .greater_than(o_gt[2]), .equal(o_eq[2]),
        .less_than(o_lt[2]), .x_bit(o_x[2]), .y_bit(o_y[2]), .bit_valid(o_bv[2]),
        .bit_index(idx2));

    // Model: m_t counts cycles since the accepted start (1..len shifting, len+1 done).
    int         m_t   [3] = '{0, 0, 0};
    int         m_len [3] = '{8, 8, 1};
    logic [7:0] m_a   [3];
    logic [7:0] m_b   [3];
    bit         m_gt  [3] = '{0, 0, 0};
    bit         m_eq  [3] = '{0, 0, 0};
    bit         m_lt  [3] = '{0, 0, 0};

    function automatic int calc_len(int w, bit e, logic [7:0] x, logic [7:0] y);
        if (!e) return w;
        for (int i = w - 1; i >= 0; i--)
            if (x[i] != y[i]) return w - i;
        return w;
    endfunction

    task automatic chk(string name, int k, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s dut%0d t=%0t actual=%0d required=%0d", name, k, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst[k]) begin
                m_t[k]  <= 0;
                m_gt[k] <= 1'b0;
                m_eq[k] <= 1'b0;
                m_lt[k] <= 1'b0;
            end else if (m_t[k] == 0) begin
                if (start[k]) begin
                    m_t[k]   <= 1;
                    m_a[k]   <= a_in[k] & ((wd[k] == 8) ? 8'hFF : 8'h01);
                    m_b[k]   <= b_in[k] & ((wd[k] == 8) ? 8'hFF : 8'h01);
                    m_len[k] <= calc_len(wd[k], ee[k],
                                         a_in[k] & ((wd[k] == 8) ? 8'hFF : 8'h01),
                                         b_in[k] & ((wd[k] == 8) ? 8'hFF : 8'h01));
                end
            end else if (m_t[k] < m_len[k]) begin
                m_t[k] <= m_t[k] + 1;
            end else if (m_t[k] == m_len[k]) begin
                m_t[k]  <= m_t[k] + 1;
                m_gt[k] <= (m_a[k] > m_b[k]);
                m_eq[k] <= (m_a[k] == m_b[k]);
                m_lt[k] <= (m_a[k] < m_b[k]);
            end else begin
                m_t[k] <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (run_chk) begin
            for (int k = 0; k < 3; k++) begin
                int t;
                bit bv;
                int act_idx;
                t  = m_t[k];
                bv = (t >= 1) && (t <= m_len[k]);
                act_idx = (k == 0) ? int'(idx0) : (k == 1) ? int'(idx1) : int'(idx2);
                chk("busy",      k, int'(o_busy[k]), int'(t != 0));
                chk("done",      k, int'(o_done[k]), int'(t == m_len[k] + 1));
                chk("bit_valid", k, int'(o_bv[k]),   int'(bv));
                chk("bit_index", k, act_idx,         bv ? wd[k] - t : 0);
                chk("x_bit",     k, int'(o_x[k]),    bv ? int'(m_a[k][wd[k] - t]) : 0);
                chk("y_bit",     k, int'(o_y[k]),    bv ? int'(m_b[k][wd[k] - t]) : 0);
                chk("greater",   k, int'(o_gt[k]),   int'(m_gt[k]));
                chk("equal",     k, int'(o_eq[k]),   int'(m_eq[k]));
                chk("less",      k, int'(o_lt[k]),   int'(m_lt[k]));
            end
        end
    end

    initial begin
        logic [7:0] pat;
        int         n_done;
        int         exp_code [4] = '{1, 2, 0, 1};  // 0 less, 1 equal, 2 greater

        rst   = 3'b111;
        start = 3'b000;
        for (int k = 0; k < 3; k++) begin
            a_in[k] = 8'h00;
            b_in[k] = 8'h00;
        end
        step();
        step();
        rst     = 3'b000;
        run_chk = 1'b1;
        chk("reset_busy", 0, int'(o_busy[0]), 0);
        chk("reset_eq",   0, int'(o_eq[0]),   0);

        // Equal operands: serial bit stream and equal result
        pat = 8'h3C;
        a_in[0] = 8'h3C; b_in[0] = 8'h3C; start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("seq_x",   0, int'(o_x[0]), int'(pat[7 - i]));
            chk("seq_y",   0, int'(o_y[0]), int'(pat[7 - i]));
            chk("seq_idx", 0, int'(idx0),   7 - i);
            step();
        end
        chk("3c_done", 0, int'(o_done[0]), 1);
        chk("3c_eq",   0, int'(o_eq[0]),   1);
        chk("3c_gt",   0, int'(o_gt[0]),   0);
        chk("3c_lt",   0, int'(o_lt[0]),   0);
        step();

        a_in[0] = 8'h80; b_in[0] = 8'h7F; start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        repeat (8) step();
        chk("80_done", 0, int'(o_done[0]), 1);
        chk("80_gt",   0, int'(o_gt[0]),   1);
        chk("80_lt",   0, int'(o_lt[0]),   0);
        step();
        a_in[0] = 8'h7F; b_in[0] = 8'h80; start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        repeat (8) step();
        chk("7f_done", 0, int'(o_done[0]), 1);
        chk("7f_lt",   0, int'(o_lt[0]),   1);
        chk("7f_gt",   0, int'(o_gt[0]),   0);
        step();

        // Early exit at bit 4, then no difference at all
        a_in[1] = 8'h10; b_in[1] = 8'h00; start[1] = 1'b1;
        step();
        start[1] = 1'b0;
        repeat (3) step();
        chk("ee_not_yet", 1, int'(o_done[1]), 0);
        step();
        chk("ee_done", 1, int'(o_done[1]), 1);
        chk("ee_gt",   1, int'(o_gt[1]),   1);
        step();
        a_in[1] = 8'hFF; b_in[1] = 8'hFF; start[1] = 1'b1;
        step();
        start[1] = 1'b0;
        repeat (8) step();
        chk("eeff_done", 1, int'(o_done[1]), 1);
        chk("eeff_eq",   1, int'(o_eq[1]),   1);
        step();

        // Reset in the third shift cycle discards the compare
        a_in[0] = 8'hA5; b_in[0] = 8'h5A; start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        step();
        step();
        rst[0] = 1'b1;
        step();
        rst[0] = 1'b0;
        chk("rst_busy", 0, int'(o_busy[0]), 0);
        chk("rst_done", 0, int'(o_done[0]), 0);
        chk("rst_bv",   0, int'(o_bv[0]),   0);
        chk("rst_res",  0, int'({o_gt[0], o_eq[0], o_lt[0]}), 0);
        n_done = 0;
        repeat (10) begin
            step();
            n_done += int'(o_done[0]);
        end
        chk("rst_no_done", 0, n_done, 0);

        // start held high: one compare every WIDTH+2 cycles
        a_in[0] = 8'h01; b_in[0] = 8'h02; start[0] = 1'b1;
        n_done = 0;
        repeat (30) begin
            step();
            if (o_done[0]) begin
                n_done++;
                chk("held_lt", 0, int'(o_lt[0]), 1);
            end
        end
        start[0] = 1'b0;
        chk("held_count", 0, n_done, 3);
        repeat (10) step();

        // WIDTH=1, all operand pairs
        for (int p = 0; p < 4; p++) begin
            a_in[2] = (p == 1 || p == 3) ? 8'h01 : 8'h00;
            b_in[2] = (p == 2 || p == 3) ? 8'h01 : 8'h00;
            start[2] = 1'b1;
            step();
            start[2] = 1'b0;
            step();
            chk("w1_done", 2, int'(o_done[2]), 1);
            chk("w1_res",  2, o_gt[2] ? 2 : (o_eq[2] ? 1 : (o_lt[2] ? 0 : 3)), exp_code[p]);
            step();
        end

        // Random traffic on all three instances
        repeat (3000) begin
            for (int k = 0; k < 3; k++) begin
                rst[k]   = ($urandom_range(0, 79) == 0);
                start[k] = ($urandom_range(0, 2) != 0);
                a_in[k]  = 8'($urandom);
                if ($urandom_range(0, 3) == 0)
                    b_in[k] = a_in[k];
                else if ($urandom_range(0, 1) == 0)
                    b_in[k] = a_in[k] ^ (8'h01 << $urandom_range(0, 7));
                else
                    b_in[k] = 8'($urandom);
            end
            step();
        end
        rst   = 3'b000;
        start = 3'b000;
        repeat (12) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
